cfg_chain_loader: RTL
=====================

Name: cfg_chain_loader

Overview:
- Sequencer that loads one PE block's serial configuration chain from a word-wide bitstream source.
- Accepts config words over a valid/ready stream, pulses the chain reset, then bit-serialises CHAIN_BITS bits onto config_in with a generated config_clk.
- Sits between the array-level bitstream fetcher and each BlockPE-style cell's config_clk/config_reset/config_in pins.

Parameters:
- CHAIN_BITS, 14, total config bits in the target chain (≥1).
- WORD_W, 32, width of incoming bitstream words.
- RST_CYCLES, 2, number of clk cycles config_reset is held high before shifting (≥1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel a load in progress.
- cfg_word  input  WORD_W  bitstream word.
- cfg_valid  input  1  cfg_word valid.
- cfg_ready  output  1  loader accepts cfg_word this cycle.
- config_clk  output  1  generated chain shift clock.
- config_reset  output  1  chain reset, active-high.
- config_in  output  1  serial data into the chain.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on successful completion.
- aborted  output  1  one-cycle pulse when abort is taken.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; all outputs 0; counters 0. Applies mid-load; the chain is left partially loaded.
- States: IDLE, CRST, FETCH, SETUP, PULSE, DONE.
- IDLE:
  - start=1 → CRST.
  - Outputs 0.
- CRST:
  - config_reset=1 for exactly RST_CYCLES cycles, counted by rst_cnt.
  - Then → FETCH.
- FETCH:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, latch cfg_word into shift register sreg; set wbit=0; → SETUP.
  - Stays in FETCH while cfg_valid=0.
- SETUP:
  - config_clk=0; config_in=sreg[0], registered so it is stable for the whole phase.
  - → PULSE.
- PULSE:
  - config_clk=1; config_in holds its value.
  - At exit: sreg>>=1; bit_cnt++; wbit++.
  - If bit_cnt reaches CHAIN_BITS → DONE.
  - Else if wbit reaches WORD_W → FETCH.
  - Else → SETUP.
- DONE:
  - done=1 for one cycle, then → IDLE.
- Bit order:
  - Stream bit k = cfg_word[k mod WORD_W] of word ⌊k/WORD_W⌋; bit 0 is shifted first.
  - Unused upper bits of the final word are discarded.
- Exactly ⌈CHAIN_BITS/WORD_W⌉ words are consumed per load; no extra handshakes occur.
- Exactly CHAIN_BITS rising edges of config_clk occur per load.
- Every config_clk rising edge is preceded by ≥1 clk cycle of stable config_in.
- All outputs are registered (glitch-free config_clk).
- abort=1 in any non-IDLE state (takes priority over all transitions):
  - Next state IDLE; aborted=1 for one cycle.
  - config_clk and config_in forced to 0; cfg_ready=0 that cycle. A word offered in the same cycle is not consumed.
- start while busy: ignored.
- start and abort together in IDLE: abort has no effect; the load starts.
- Counter widths: bit_cnt is $clog2(CHAIN_BITS+1); wbit is $clog2(WORD_W+1). Neither wraps within a load.
- Latency with cfg_valid held high (cycles counted after the start edge):
  - CRST: 1..RST_CYCLES.
  - Each FETCH: 1 cycle.
  - Each bit: 2 cycles.
  - DONE: 1 cycle.

Decomposition:
- Shared package cfg_pkg:
  - state enum (IDLE, CRST, FETCH, SETUP, PULSE, DONE).
  - localparam helper for words-per-load = ⌈CHAIN_BITS/WORD_W⌉.
- No sub-module needed. Optional sub-module cfg_serializer (sreg + wbit + SETUP/PULSE phase) if reused by the array-level loader.

Test Plan:
- Nominal, CHAIN_BITS=14, WORD_W=8, RST_CYCLES=2; words 0xA5 then 0x3C, valid always high, start at t0:
  - config_reset high in cycles 1–2; words accepted in cycles 3 and 20.
  - config_in sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1.
  - 14 config_clk pulses; done in cycle 33; busy high cycles 1–33.
- Stall: hold cfg_valid=0 for 5 cycles in the second FETCH → config_clk stays 0 and cfg_ready stays 1 throughout; done moves to cycle 38; bit stream unchanged.
- Abort: assert abort during the 4th PULSE → next cycle IDLE, aborted=1 for one cycle, config_clk=0; exactly 4 clk pulses emitted; the second word is never accepted (cfg_ready never high again).
- Reset mid-load: reset=0 during the second FETCH → next edge all outputs 0, state IDLE; a new start then performs a full load matching the nominal scenario.
- Edge geometry, CHAIN_BITS=32, WORD_W=32: a single handshake, 32 pulses, no second FETCH; check last bit = cfg_word[31].
- Ignore start while busy: pulse start in cycle 10 of a load → no restart, done still in cycle 33.

Source files
------------

// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - state encoding and sizing helper shared by the config chain loader
package cfg_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_FETCH,
    S_SETUP,
    S_PULSE,
    S_DONE
  } state_t;

  function automatic int words_per_load(input int chain_bits, input int word_w);
    return (chain_bits + word_w - 1) / word_w;
  endfunction
endpackage

// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - loads one PE serial config chain from a word-wide bitstream
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_BITS = 14,
  parameter int WORD_W     = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              config_clk,
  output logic              config_reset,
  output logic              config_in,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int BCW = $clog2(CHAIN_BITS + 1);
  localparam int WBW = $clog2(WORD_W + 1);
  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_END  = BCW'(CHAIN_BITS);
  localparam logic [WBW-1:0] WBIT_END = WBW'(WORD_W);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [RCW-1:0]    r_rst_cnt, w_rst_cnt_nxt;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [WBW-1:0]    r_wbit, w_wbit_nxt;
  logic [WORD_W-1:0] r_sreg, w_sreg_nxt;
  logic              r_ready, r_cclk, r_creset, r_cin, r_busy, r_done, r_aborted;
  logic              w_abort, w_take;

  // An abort withdraws ready in the same cycle so an offered word is left upstream.
  assign w_abort = abort && (r_state != S_IDLE);
  assign w_take  = r_ready && cfg_valid && !abort;

  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_wbit_nxt    = r_wbit;
    w_sreg_nxt    = r_sreg;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_CRST;
          w_rst_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end
      end
      S_CRST: begin
        if (r_rst_cnt == RST_LAST) w_state_nxt = S_FETCH;
        else w_rst_cnt_nxt = r_rst_cnt + RCW'(1);
      end
      S_FETCH: begin
        if (w_take) begin
          w_sreg_nxt  = cfg_word;
          w_wbit_nxt  = '0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_PULSE;
      S_PULSE: begin
        w_sreg_nxt    = r_sreg >> 1;
        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
        w_wbit_nxt    = r_wbit + WBW'(1);
        if (w_bit_cnt_nxt == BIT_END) w_state_nxt = S_DONE;
        else if (w_wbit_nxt == WBIT_END) w_state_nxt = S_FETCH;
        else w_state_nxt = S_SETUP;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= '0;
      r_bit_cnt <= '0;
      r_wbit    <= '0;
      r_sreg    <= '0;
      r_ready   <= 1'b0;
      r_cclk    <= 1'b0;
      r_creset  <= 1'b0;
      r_cin     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= w_rst_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_wbit    <= w_wbit_nxt;
      r_sreg    <= w_sreg_nxt;
      r_ready   <= (w_state_nxt == S_FETCH);
      r_cclk    <= (w_state_nxt == S_PULSE);
      r_creset  <= (w_state_nxt == S_CRST);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_aborted <= w_abort;
      // config_in is set up a full cycle ahead of the config_clk rise and held through it.
      if (w_state_nxt == S_SETUP) r_cin <= w_sreg_nxt[0];
      else if (w_state_nxt != S_PULSE) r_cin <= 1'b0;
    end
  end

  assign cfg_ready    = r_ready && !abort;
  assign config_clk   = r_cclk;
  assign config_reset = r_creset;
  assign config_in    = r_cin;
  assign busy         = r_busy;
  assign done         = r_done;
  assign aborted      = r_aborted;
endmodule
